dcache_flush_unit: RTL and testbench

DCACHE_FLUSH_UNIT -- requirements
Module: dcache_flush_unit

---
 rtl/dcache_flush_unit_pkg.sv | 18 +
 rtl/dcache_flush_unit_if.sv | 45 ++++
 rtl/dcache_flush_unit_lzc.sv | 30 +++
 rtl/dcache_flush_unit.sv | 139 +++++++++++++
 tb/tb_dcache_flush_unit.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_flush_unit_pkg.sv
// Shared constants and helpers for the data-cache flush unit and its
// lowest-set-bit counter.
package dcache_flush_unit_pkg;

  // Default data-cache geometry of the core.
  localparam int unsigned DCACHE_NUM_SETS = 256;
  localparam int unsigned DCACHE_NUM_WAYS = 8;

  // Counting direction of the zero counter.
  localparam bit LZC_TRAILING = 1'b0;
  localparam bit LZC_LEADING  = 1'b1;

  // Index width for a power-of-two count, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_flush_unit_if.sv
// Port bundle between the flush unit, the flush controller and the data cache
// metadata, writeback and invalidate ports.
interface dcache_flush_unit_if
  import dcache_flush_unit_pkg::*;
#(
  parameter int unsigned NUM_SETS = DCACHE_NUM_SETS,
  parameter int unsigned NUM_WAYS = DCACHE_NUM_WAYS
);

  localparam int unsigned IDX_W = idx_width(NUM_SETS);
  localparam int unsigned WAY_W = idx_width(NUM_WAYS);

  // Handshakes: meta_req_o / wb_req_o stay high with index/way stable until the
  // matching *_gnt_i is high at a rising edge; the transfer happens on that edge.
  // Metadata answers in the cycle after its grant; wb_done_i is a one-cycle pulse.
  logic                flush_i;
  logic                flush_ack_o;
  logic                busy_o;
  logic                meta_req_o;
  logic [IDX_W-1:0]    meta_idx_o;
  logic                meta_gnt_i;
  logic [NUM_WAYS-1:0] meta_valid_i;
  logic [NUM_WAYS-1:0] meta_dirty_i;
  logic                wb_req_o;
  logic [IDX_W-1:0]    wb_idx_o;
  logic [WAY_W-1:0]    wb_way_o;
  logic                wb_gnt_i;
  logic                wb_done_i;
  logic                inv_we_o;
  logic [IDX_W-1:0]    inv_idx_o;
  logic [2:0]          dbg_state_o;

  modport master (
    input  flush_i, meta_gnt_i, meta_valid_i, meta_dirty_i, wb_gnt_i, wb_done_i,
    output flush_ack_o, busy_o, meta_req_o, meta_idx_o, wb_req_o, wb_idx_o,
           wb_way_o, inv_we_o, inv_idx_o, dbg_state_o
  );

  modport slave (
    output flush_i, meta_gnt_i, meta_valid_i, meta_dirty_i, wb_gnt_i, wb_done_i,
    input  flush_ack_o, busy_o, meta_req_o, meta_idx_o, wb_req_o, wb_idx_o,
           wb_way_o, inv_we_o, inv_idx_o, dbg_state_o
  );

endinterface

// File: rtl/dcache_flush_unit_lzc.sv
// Leading/trailing zero counter; in trailing mode cnt_o is the index of the
// lowest set bit of in_i. cnt_o is 0 and empty_o is 1 for an all-zero input.
module dcache_flush_unit_lzc
  import dcache_flush_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter bit          MODE  = LZC_TRAILING
) (
  input  logic [WIDTH-1:0]                 in_i,
  output logic [idx_width(WIDTH)-1:0]      cnt_o,
  output logic                             empty_o
);

  localparam int unsigned CNT_W = idx_width(WIDTH);

  // Scanning from the top down lets the last hit win, i.e. the smallest count.
  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (MODE == LZC_LEADING) begin
        if (in_i[WIDTH-1-i]) cnt_o = CNT_W'(i);
      end else begin
        if (in_i[i]) cnt_o = CNT_W'(i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/dcache_flush_unit.sv
// Walks every cache set: reads its metadata, writes back each valid+dirty way
// lowest-first, invalidates the set, and acknowledges once the last set is done.
module dcache_flush_unit
  import dcache_flush_unit_pkg::*;
#(
  parameter int unsigned NUM_SETS = DCACHE_NUM_SETS,
  parameter int unsigned NUM_WAYS = DCACHE_NUM_WAYS
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dcache_flush_unit_if.master bus
);

  localparam int unsigned     IDX_W    = idx_width(NUM_SETS);
  localparam int unsigned     WAY_W    = idx_width(NUM_WAYS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    META_REQ = 3'd1,
    META_RSP = 3'd2,
    WB_REQ   = 3'd3,
    WB_WAIT  = 3'd4,
    INVAL    = 3'd5,
    DONE     = 3'd6,
    DRAIN    = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_WAYS-1:0] pending_q, pending_d;
  logic [WAY_W-1:0]    wb_way;
  logic                pending_empty;
  logic [NUM_WAYS-1:0] clr_mask;
  logic                meta_req, wb_req, inv_we, flush_ack;

  dcache_flush_unit_lzc #(
    .WIDTH (NUM_WAYS),
    .MODE  (LZC_TRAILING)
  ) i_lzc (
    .in_i    (pending_q),
    .cnt_o   (wb_way),
    .empty_o (pending_empty)
  );

  // The way in flight is the lowest pending bit; pending only changes on its done.
  assign clr_mask = {{(NUM_WAYS-1){1'b0}}, 1'b1} << wb_way;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        if (bus.flush_i) begin
          idx_d   = '0;
          state_d = META_REQ;
        end
      end
      META_REQ: begin
        if (bus.meta_gnt_i) state_d = META_RSP;
      end
      META_RSP: begin
        pending_d = bus.meta_valid_i & bus.meta_dirty_i;
        state_d   = (|pending_d) ? WB_REQ : INVAL;
      end
      WB_REQ: begin
        if (pending_empty)       state_d = INVAL;
        else if (bus.wb_gnt_i)   state_d = WB_WAIT;
      end
      WB_WAIT: begin
        if (bus.wb_done_i) begin
          pending_d = pending_q & ~clr_mask;
          state_d   = (|pending_d) ? WB_REQ : INVAL;
        end
      end
      INVAL: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = META_REQ;
        end
      end
      DONE: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        // A level request still high after the ack must not start another walk.
        if (!bus.flush_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
    end
  end

  assign meta_req  = (state_q == META_REQ);
  assign wb_req    = (state_q == WB_REQ) && !pending_empty;
  assign inv_we    = (state_q == INVAL);
  assign flush_ack = (state_q == DONE);

  // Index/way buses read as zero whenever their strobe is low.
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.meta_req_o  = meta_req;
  assign bus.meta_idx_o  = meta_req ? idx_q : '0;
  assign bus.wb_req_o    = wb_req;
  assign bus.wb_idx_o    = wb_req ? idx_q : '0;
  assign bus.wb_way_o    = wb_req ? wb_way : '0;
  assign bus.inv_we_o    = inv_we;
  assign bus.inv_idx_o   = inv_we ? idx_q : '0;
  assign bus.flush_ack_o = flush_ack;
  assign bus.dbg_state_o = state_q;

  a_strobes_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0({meta_req, wb_req, inv_we, flush_ack}));

  a_meta_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (meta_req && !bus.meta_gnt_i) |=> (meta_req && $stable(bus.meta_idx_o)));

  a_wb_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (wb_req && !bus.wb_gnt_i) |=> (wb_req && $stable(bus.wb_idx_o) && $stable(bus.wb_way_o)));

  a_ack_single: assert property (@(posedge clk_i) disable iff (rst_i)
    flush_ack |=> !flush_ack);

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Bench for dcache_flush_unit: directed cache images, a cache-side responder and
// an event-queue model of the expected set walk, plus literal spot checks.
module tb_dcache_flush_unit;

  localparam int SETS = 4;
  localparam int WAYS = 8;
  localparam int IW   = $clog2(SETS);
  localparam int WW   = $clog2(WAYS);
  localparam int EW   = 2 + IW + WW;
  localparam logic [1:0] EV_META = 2'd0, EV_WB = 2'd1, EV_INV = 2'd2, EV_ACK = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_flush_unit_if #(.NUM_SETS(SETS), .NUM_WAYS(WAYS)) bus ();

  dcache_flush_unit #(.NUM_SETS(SETS), .NUM_WAYS(WAYS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [WAYS-1:0] vmem [SETS];
  logic [WAYS-1:0] dmem [SETS];
  int meta_dly = 0, wb_gnt_dly = 0, wb_done_dly = 0;
  bit stray_done = 1'b0;

  logic [EW-1:0] exp_q[$];
  int n_meta = 0, n_wb = 0, n_inv = 0, n_ack = 0, n_wb_req_cyc = 0, ack_cyc = 0;
  logic [IW-1:0] meta_log[$];
  logic [IW-1:0] wb_idx_log[$];
  logic [WW-1:0] wb_way_log[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_ev(input logic [1:0] k, input logic [IW-1:0] idx,
                                          input logic [WW-1:0] way);
    return {k, idx, way};
  endfunction

  task automatic expect_ev(input string name, input logic [EW-1:0] got);
    logic [EW-1:0] want;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got event 0x%0h expected no event", name, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got event 0x%0h expected 0x%0h", name, got, want);
      end
    end
  endtask

  // Whole flush as a list of events: per set one metadata read, a writeback for
  // each valid+dirty way in ascending order, one invalidate; then one ack.
  task automatic build_expected();
    exp_q.delete();
    for (int s = 0; s < SETS; s++) begin
      logic [WAYS-1:0] pend;
      pend = vmem[s] & dmem[s];
      exp_q.push_back(mk_ev(EV_META, IW'(s), '0));
      for (int w = 0; w < WAYS; w++)
        if (pend[w]) exp_q.push_back(mk_ev(EV_WB, IW'(s), WW'(w)));
      exp_q.push_back(mk_ev(EV_INV, IW'(s), '0));
    end
    exp_q.push_back(mk_ev(EV_ACK, '0, '0));
  endtask

  // Cache-side responder and per-cycle compare, both at the falling edge.
  initial begin : responder
    int meta_wait, wb_wait, done_cnt;
    bit done_armed, rsp_pend, meta_hold, wb_hold;
    logic [IW-1:0] rsp_idx, hold_meta_idx, hold_wb_idx;
    logic [WW-1:0] hold_wb_way;
    meta_wait = 0; wb_wait = 0; done_cnt = 0;
    done_armed = 1'b0; rsp_pend = 1'b0; meta_hold = 1'b0; wb_hold = 1'b0;
    rsp_idx = '0; hold_meta_idx = '0; hold_wb_idx = '0; hold_wb_way = '0;
    bus.meta_gnt_i   = 1'b0;
    bus.meta_valid_i = '0;
    bus.meta_dirty_i = '0;
    bus.wb_gnt_i     = 1'b0;
    bus.wb_done_i    = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_pend) begin
        bus.meta_valid_i = vmem[rsp_idx];
        bus.meta_dirty_i = dmem[rsp_idx];
      end else begin
        bus.meta_valid_i = WAYS'($urandom);
        bus.meta_dirty_i = WAYS'($urandom);
      end
      if (bus.meta_req_o) begin
        bus.meta_gnt_i = (meta_wait >= meta_dly);
        meta_wait++;
      end else begin
        bus.meta_gnt_i = 1'b0;
        meta_wait = 0;
      end
      if (bus.wb_req_o) begin
        bus.wb_gnt_i = (wb_wait >= wb_gnt_dly);
        wb_wait++;
      end else begin
        bus.wb_gnt_i = 1'b0;
        wb_wait = 0;
      end
      bus.wb_done_i = (done_armed && done_cnt == 0) || (stray_done && bus.meta_req_o);

      chk("strobe_exclusive",
          32'($countones({bus.meta_req_o, bus.wb_req_o, bus.inv_we_o, bus.flush_ack_o}) <= 1), 1);
      if (bus.meta_req_o || bus.wb_req_o || bus.inv_we_o || bus.flush_ack_o)
        chk("busy_while_active", 32'(bus.busy_o), 1);
      if (meta_hold) begin
        chk("meta_req_held", 32'(bus.meta_req_o), 1);
        chk("meta_idx_stable", 32'(bus.meta_idx_o), 32'(hold_meta_idx));
      end
      if (wb_hold) begin
        chk("wb_req_held", 32'(bus.wb_req_o), 1);
        chk("wb_idx_stable", 32'(bus.wb_idx_o), 32'(hold_wb_idx));
        chk("wb_way_stable", 32'(bus.wb_way_o), 32'(hold_wb_way));
      end

      if (bus.meta_req_o && bus.meta_gnt_i) begin
        n_meta++;
        meta_log.push_back(bus.meta_idx_o);
        expect_ev("meta_event", mk_ev(EV_META, bus.meta_idx_o, '0));
      end
      if (bus.wb_req_o) n_wb_req_cyc++;
      if (bus.wb_req_o && bus.wb_gnt_i) begin
        n_wb++;
        wb_idx_log.push_back(bus.wb_idx_o);
        wb_way_log.push_back(bus.wb_way_o);
        expect_ev("wb_event", mk_ev(EV_WB, bus.wb_idx_o, bus.wb_way_o));
      end
      if (bus.inv_we_o) begin
        n_inv++;
        expect_ev("inv_event", mk_ev(EV_INV, bus.inv_idx_o, '0));
      end
      if (bus.flush_ack_o) begin
        n_ack++;
        ack_cyc = cyc;
        expect_ev("ack_event", mk_ev(EV_ACK, '0, '0));
      end

      rsp_pend      = bus.meta_req_o && bus.meta_gnt_i;
      rsp_idx       = bus.meta_idx_o;
      meta_hold     = bus.meta_req_o && !bus.meta_gnt_i;
      hold_meta_idx = bus.meta_idx_o;
      wb_hold       = bus.wb_req_o && !bus.wb_gnt_i;
      hold_wb_idx   = bus.wb_idx_o;
      hold_wb_way   = bus.wb_way_o;
      if (bus.wb_req_o && bus.wb_gnt_i) begin
        done_armed = 1'b1;
        done_cnt   = wb_done_dly;
      end else if (done_armed) begin
        if (done_cnt == 0) done_armed = 1'b0;
        else done_cnt--;
      end
      if (rst) begin
        exp_q.delete();
        rsp_pend = 1'b0; meta_hold = 1'b0; wb_hold = 1'b0; done_armed = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input int start_ack, input int budget, input string name);
    int n;
    n = 0;
    while (n_ack == start_ack && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(n_ack - start_ack), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},      32'(bus.busy_o), 0);
    chk({tag, "_flush_ack"}, 32'(bus.flush_ack_o), 0);
    chk({tag, "_meta_req"},  32'(bus.meta_req_o), 0);
    chk({tag, "_meta_idx"},  32'(bus.meta_idx_o), 0);
    chk({tag, "_wb_req"},    32'(bus.wb_req_o), 0);
    chk({tag, "_wb_idx"},    32'(bus.wb_idx_o), 0);
    chk({tag, "_wb_way"},    32'(bus.wb_way_o), 0);
    chk({tag, "_inv_we"},    32'(bus.inv_we_o), 0);
    chk({tag, "_inv_idx"},   32'(bus.inv_idx_o), 0);
  endtask

  initial begin : main
    int a0, c0, m0, w0, i0, r0, n;
    int t2_idx[5];
    int t2_way[5];
    t2_idx = '{1, 1, 2, 2, 2};
    t2_way = '{0, 1, 2, 5, 7};
    bus.flush_i = 1'b0;
    for (int s = 0; s < SETS; s++) begin
      vmem[s] = '0;
      dmem[s] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("reset");

    // All-clean cache, immediate grants, flush held through the ack.
    build_expected();
    a0 = n_ack; m0 = n_meta; w0 = n_wb; i0 = n_inv;
    tick();
    c0 = cyc;
    bus.flush_i = 1'b1;
    wait_ack(a0, 200, "t1_ack_seen");
    chk("t1_ack_latency", 32'(ack_cyc - c0), 13);
    chk("t1_inv_count",   32'(n_inv - i0), 4);
    chk("t1_wb_count",    32'(n_wb - w0), 0);
    chk("t1_meta_count",  32'(n_meta - m0), 4);
    m0 = n_meta;
    tick();
    chk("t1_drain_busy", 32'(bus.busy_o), 1);
    tick();
    bus.flush_i = 1'b0;
    repeat (4) tick();
    chk("t1_no_restart",  32'(n_meta - m0), 0);
    chk("t1_idle_busy",   32'(bus.busy_o), 0);
    chk("t1_queue_empty", 32'(exp_q.size()), 0);

    // Mixed image, one-cycle flush pulse, slow grants, stray done in META_REQ.
    vmem[0] = 8'h00; dmem[0] = 8'hFF;
    vmem[1] = 8'h0F; dmem[1] = 8'h03;
    vmem[2] = 8'hFF; dmem[2] = 8'hA4;
    vmem[3] = 8'hF0; dmem[3] = 8'h0F;
    meta_dly = 2; wb_gnt_dly = 5; wb_done_dly = 3; stray_done = 1'b1;
    build_expected();
    wb_idx_log.delete(); wb_way_log.delete();
    a0 = n_ack; w0 = n_wb; r0 = n_wb_req_cyc;
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    wait_ack(a0, 600, "t2_ack_seen");
    stray_done = 1'b0;
    chk("t2_wb_count",      32'(n_wb - w0), 5);
    chk("t2_wb_req_cycles", 32'(n_wb_req_cyc - r0), 30);
    chk("t2_wb_log_size",   32'(wb_idx_log.size()), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < wb_idx_log.size()) begin
        chk("t2_wb_idx", 32'(wb_idx_log[k]), t2_idx[k]);
        chk("t2_wb_way", 32'(wb_way_log[k]), t2_way[k]);
      end
    end
    repeat (3) tick();
    chk("t2_idle_busy",   32'(bus.busy_o), 0);
    chk("t2_queue_empty", 32'(exp_q.size()), 0);

    // Reset while a writeback is outstanding, then a clean restart.
    meta_dly = 0; wb_gnt_dly = 1; wb_done_dly = 6;
    build_expected();
    w0 = n_wb; a0 = n_ack;
    bus.flush_i = 1'b1;
    n = 0;
    while (n_wb == w0 && n < 200) begin
      tick();
      n++;
    end
    chk("t3_wb_accepted", 32'(n_wb - w0), 1);
    rst = 1'b1;
    bus.flush_i = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("t3_after_rst");
    chk("t3_no_ack_on_abort", 32'(n_ack - a0), 0);
    build_expected();
    meta_log.delete();
    a0 = n_ack;
    tick();
    bus.flush_i = 1'b1;
    wait_ack(a0, 400, "t3_restart_ack");
    bus.flush_i = 1'b0;
    chk("t3_first_meta_idx", (meta_log.size() > 0) ? 32'(meta_log[0]) : 32'hFFFF_FFFF, 0);
    chk("t3_meta_count", 32'(meta_log.size()), 4);
    repeat (3) tick();
    chk("t3_idle_busy",   32'(bus.busy_o), 0);
    chk("t3_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have ended", $time);
    $fatal(1);
  end

endmodule
